main_control_fsm: RTL and testbench

Multicycle main controller for the RISC-V CPU. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives datapath selects, write strobes and the 2-bit `aluop` consumed by the ALU control decoder. It sits between the instruction register (opcode), the ALU (zero flag) and the datapath muxes. It also keeps a retired-instruction counter.

---
 rtl/main_control_fsm_pkg.sv | 45 ++++
 rtl/main_control_fsm_if.sv | 33 +++
 rtl/main_control_fsm_decode.sv | 67 ++++++
 rtl/main_control_fsm.sv | 87 ++++++++
 tb/tb_main_control_fsm.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/main_control_fsm_pkg.sv
// Shared types and encodings for the multicycle main controller.
// Imported by the controller, its decoder and the bench.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_ALUWB,
    S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // States whose exit retires an instruction.
  function automatic logic is_retire(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWRITE) ||
           (s == S_ALUWB) || (s == S_BEQ);
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Controller <-> datapath bundle; master is the controller,
// slave is the datapath side that supplies opcode and zero.
interface main_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic             reg_write;
  logic [1:0]       aluop;
  logic             illegal_op;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero,
    output pc_write, adr_src, mem_write, ir_write,
    output result_src, alu_src_a, alu_src_b,
    output reg_write, aluop, illegal_op, instret
  );

  modport slave (
    output opcode, zero,
    input  pc_write, adr_src, mem_write, ir_write,
    input  result_src, alu_src_a, alu_src_b,
    input  reg_write, aluop, illegal_op, instret
  );
endinterface

// File: rtl/main_control_fsm_decode.sv
// Pure state-to-control map; zero only feeds the BEQ pc_write.
// RST and unused encodings decode to all strobes off.
module main_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_reg_write,
  output logic [1:0] o_aluop
);

  always_comb begin
    o_pc_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_result_src = RES_ALUOUT;
    o_alu_src_a  = SRCA_PC;
    o_alu_src_b  = SRCB_RS2;
    o_reg_write  = 1'b0;
    o_aluop      = ALUOP_ADD;
    unique case (i_state)
      S_FETCH: begin
        o_ir_write   = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURES;
        o_pc_write   = 1'b1;
      end
      S_DECODE: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: o_adr_src = 1'b1;
      S_MEMWB: begin
        o_result_src = RES_RDATA;
        o_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_write = 1'b1;
      end
      S_EXECR: begin
        o_alu_src_a = SRCA_RS1;
        o_aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: o_reg_write = 1'b1;
      S_BEQ: begin
        o_alu_src_a = SRCA_RS1;
        o_aluop     = ALUOP_SUB;
        o_pc_write  = i_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main controller: state register, next-state
// logic and retired-instruction counter.
module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  main_ctrl_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic             w_illegal;
  logic [CNT_W-1:0] r_instret;

  logic w_is_lw;
  logic w_is_sw;
  logic w_is_r;
  logic w_is_beq;

  assign w_is_lw  = (bus.opcode == OP_LW);
  assign w_is_sw  = (bus.opcode == OP_SW);
  assign w_is_r   = (bus.opcode == OP_RTYPE);
  assign w_is_beq = (bus.opcode == OP_BEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    unique case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          w_is_lw, w_is_sw: w_next = S_MEMADR;
          w_is_r:           w_next = S_EXECR;
          w_is_beq:         w_next = S_BEQ;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:
        w_next = w_is_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR:    w_next = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BEQ:      w_next = S_FETCH;
      default:    w_next = S_RST;
    endcase
  end

  // Wraps silently; bumps on the edge that re-enters FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_instret <= '0;
    else if (is_retire(r_state))
      r_instret <= r_instret + 1'b1;
  end

  assign bus.instret    = r_instret;
  assign bus.illegal_op = w_illegal;

  main_ctrl_decode u_decode (
    .i_state      (r_state),
    .i_zero       (bus.zero),
    .o_pc_write   (bus.pc_write),
    .o_adr_src    (bus.adr_src),
    .o_mem_write  (bus.mem_write),
    .o_ir_write   (bus.ir_write),
    .o_result_src (bus.result_src),
    .o_alu_src_a  (bus.alu_src_a),
    .o_alu_src_b  (bus.alu_src_b),
    .o_reg_write  (bus.reg_write),
    .o_aluop      (bus.aluop)
  );

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized bench for main_control_fsm against a
// per-instruction cycle model plus a retire counter.
module tb_main_control_fsm;
  import riscv_ctrl_pkg::*;

  localparam int W_CNT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_instret = 0;

  main_ctrl_if #(.CNT_W(32))    b ();
  main_ctrl_if #(.CNT_W(W_CNT)) b2 ();

  main_control_fsm #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  main_control_fsm #(.CNT_W(W_CNT)) dut_w (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (b2)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, result_src,
  //  alu_src_a, alu_src_b, reg_write, aluop, illegal_op}
  logic [13:0] obs;
  assign obs = {b.pc_write, b.adr_src, b.mem_write,
                b.ir_write, b.result_src, b.alu_src_a,
                b.alu_src_b, b.reg_write, b.aluop,
                b.illegal_op};

  localparam int C_LW = 0, C_SW = 1, C_R = 2;
  localparam int C_BEQ = 3, C_ILL = 4;

  function automatic int lat(input int c);
    case (c)
      C_LW:    return 5;
      C_SW:    return 4;
      C_R:     return 4;
      C_BEQ:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [13:0] mk(
    input logic pcw, input logic adr, input logic mw,
    input logic irw, input logic [1:0] rs,
    input logic [1:0] sa, input logic [1:0] sb,
    input logic rw, input logic [1:0] op,
    input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, op, ill};
  endfunction

  // Expected controls for cycle k of an instruction of class c.
  function automatic logic [13:0] expv(
    input int c, input int k, input logic z);
    if (k == 0)
      return mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0);
    if (k == 1)
      return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00,
                c == C_ILL);
    case (c)
      C_LW, C_SW: begin
        if (k == 2)
          return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0);
        if (k == 3 && c == C_LW)
          return mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        if (k == 3)
          return mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        return mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 0);
      end
      C_R: begin
        if (k == 2)
          return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0);
        return mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0);
      end
      default:
        return mk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 0);
    endcase
  endfunction

  function automatic logic [6:0] pick_op(input int c);
    logic [6:0] o;
    case (c)
      C_LW:  return OP_LW;
      C_SW:  return OP_SW;
      C_R:   return OP_RTYPE;
      C_BEQ: return OP_BEQ;
      default: begin
        o = 7'($urandom);
        while (o == OP_LW || o == OP_SW ||
               o == OP_RTYPE || o == OP_BEQ)
          o = 7'($urandom);
        return o;
      end
    endcase
  endfunction

  // Entered at a negedge while in FETCH; leaves at the
  // negedge of the next FETCH. zr < 0 means random zero.
  task automatic run_instr(input int c, input int zr);
    logic [13:0] e;
    b.opcode = pick_op(c);
    for (int k = 0; k < lat(c); k++) begin
      b.zero = (zr < 0) ? 1'($urandom) : 1'(zr);
      #1;
      e = expv(c, k, b.zero);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ctl c%0d k%0d got %b want %b",
                 c, k, obs, e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (c != C_ILL) m_instret++;
    #1;
    checks++;
    if (b.instret !== m_instret) begin
      errors++;
      $display("FAIL instret c%0d got %0d want %0d",
               c, b.instret, m_instret);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    b.zero = 1'b1;
    b.opcode = OP_RTYPE;
    #1;
    checks++;
    if (obs !== 14'd0 || b.instret !== 32'd0) begin
      errors++;
      $display("FAIL reset got %b/%0d want 0/0",
               obs, b.instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL rst_state got %b want 0", obs);
    end
    @(negedge clk);
    m_instret = 0;
  endtask

  task automatic test_rtype;
    run_instr(C_R, -1);
  endtask

  task automatic test_lw_sw;
    run_instr(C_LW, -1);
    run_instr(C_SW, -1);
  endtask

  task automatic test_beq;
    run_instr(C_BEQ, 1);
    run_instr(C_BEQ, 0);
  endtask

  task automatic test_illegal;
    b.opcode = 7'b1111111;
    run_instr(C_ILL, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      run_instr(int'($urandom_range(0, 4)), -1);
  endtask

  task automatic test_mid_reset;
    b.opcode = OP_SW;
    b.zero = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (b.mem_write !== 1'b1) begin
      errors++;
      $display("FAIL memwrite_pre got %b want 1",
               b.mem_write);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 14'd0 || b.instret !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got %b/%0d want 0/0",
               obs, b.instret);
    end
    m_instret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_instr(C_R, -1);
  endtask

  task automatic test_wrap;
    logic [W_CNT-1:0] top;
    top = '1;
    b2.opcode = OP_RTYPE;
    b2.zero = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    repeat (4 * ((1 << W_CNT) - 1)) @(negedge clk);
    #1;
    checks++;
    if (b2.instret !== top) begin
      errors++;
      $display("FAIL wrap_max got %0d want %0d",
               b2.instret, top);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (b2.instret !== '0) begin
      errors++;
      $display("FAIL wrap_zero got %0d want 0",
               b2.instret);
    end
  endtask

  initial begin
    b.opcode = OP_RTYPE;
    b.zero = 1'b0;
    b2.opcode = OP_RTYPE;
    b2.zero = 1'b0;
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq();
    test_illegal();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
